// File: rtl/level_pulse_pkg.sv
// Shared encodings for the level/pulse channel array: channel modes and edge-select codes.
package level_pulse_pkg;

    localparam logic MODE_L2P = 1'b0;
    localparam logic MODE_P2L = 1'b1;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_RISE = 2'b01,
        SEL_FALL = 2'b10,
        SEL_ANY  = 2'b11
    } edge_sel_e;

endpackage

// File: rtl/level_pulse_chan.sv
// One channel: edge strobes, latched level flag and saturating event counter.
// Optional LEVEL_PULSE_SYNC_EN adds a two-flop input synchroniser and widens priming to 3 cycles.
module level_pulse_chan
    import level_pulse_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             pulse,
    input  logic             clear,
    input  logic             mode,
    input  logic [1:0]       edge_sel,
    input  logic             cnt_clr,
    output logic             pos_edge,
    output logic             neg_edge,
    output logic             any_edge,
    output logic             level_flag,
    output logic [CNT_W-1:0] evt_cnt
);

    logic       d_in;
    logic       d_q;
    logic       mode_q;
    logic [1:0] prime_cnt;

`ifdef LEVEL_PULSE_SYNC_EN
    localparam logic [1:0] PRIME_CYC = 2'd3;
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end
    assign d_in = sync2;
`else
    localparam logic [1:0] PRIME_CYC = 2'd1;
    assign d_in = d;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic primed;
    logic mode_chg;
    logic active;
    logic rise;
    logic fall;
    logic counted;

    // Edges are only trusted once every pipeline stage holds a post-reset sample.
    assign primed   = (prime_cnt == PRIME_CYC);
    assign mode_chg = (mode != mode_q);
    assign active   = primed && !mode_chg && (mode == MODE_L2P);
    assign rise     = d_in && !d_q;
    assign fall     = !d_in && d_q;
    assign counted  = active &&
                      ((rise && ((edge_sel == SEL_RISE) || (edge_sel == SEL_ANY))) ||
                       (fall && ((edge_sel == SEL_FALL) || (edge_sel == SEL_ANY))));

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q        <= 1'b0;
            mode_q     <= MODE_L2P;
            prime_cnt  <= 2'd0;
            pos_edge   <= 1'b0;
            neg_edge   <= 1'b0;
            any_edge   <= 1'b0;
            level_flag <= 1'b0;
            evt_cnt    <= '0;
        end else begin
            d_q      <= d_in;
            mode_q   <= mode;
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
            pos_edge <= active && rise;
            neg_edge <= active && fall;
            any_edge <= active && (rise || fall);

            if (mode_chg || (mode != MODE_P2L) || clear) begin
                level_flag <= 1'b0;
            end else if (pulse) begin
                level_flag <= 1'b1;
            end

            if (cnt_clr) begin
                evt_cnt <= counted ? CNT_W'(1) : '0;
            end else if (counted && (evt_cnt != CNT_MAX)) begin
                evt_cnt <= evt_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/level_pulse_array.sv
// Array of CH independent level/pulse channels with a registered interrupt reduction.
// Honours LEVEL_PULSE_SYNC_EN through the channel sub-module (input synchroniser option).
module level_pulse_array
    import level_pulse_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       d,
    input  logic [CH-1:0]       pulse,
    input  logic [CH-1:0]       clear,
    input  logic [CH-1:0]       mode,
    input  logic [2*CH-1:0]     edge_sel,
    input  logic [CH-1:0]       cnt_clr,
    input  logic [CH-1:0]       irq_en,
    output logic [CH-1:0]       pos_edge,
    output logic [CH-1:0]       neg_edge,
    output logic [CH-1:0]       any_edge,
    output logic [CH-1:0]       level_flag,
    output logic [CH*CNT_W-1:0] evt_cnt,
    output logic                irq
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        level_pulse_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .d          (d[i]),
            .pulse      (pulse[i]),
            .clear      (clear[i]),
            .mode       (mode[i]),
            .edge_sel   (edge_sel[2*i +: 2]),
            .cnt_clr    (cnt_clr[i]),
            .pos_edge   (pos_edge[i]),
            .neg_edge   (neg_edge[i]),
            .any_edge   (any_edge[i]),
            .level_flag (level_flag[i]),
            .evt_cnt    (evt_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(level_flag & irq_en);
        end
    end

endmodule

// File: tb/tb_level_pulse_array.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a negedge monitor pops and compares.
module tb_level_pulse_array;

    localparam int CH      = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef LEVEL_PULSE_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       d, pulse, clear, mode, cnt_clr, irq_en;
    logic [2*CH-1:0]     edge_sel;
    logic [CH-1:0]       pos_edge, neg_edge, any_edge, level_flag;
    logic [CH*CNT_W-1:0] evt_cnt;
    logic                irq;

    always #5 clk = ~clk;

    level_pulse_array #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .d(d), .pulse(pulse), .clear(clear), .mode(mode),
        .edge_sel(edge_sel), .cnt_clr(cnt_clr), .irq_en(irq_en),
        .pos_edge(pos_edge), .neg_edge(neg_edge), .any_edge(any_edge),
        .level_flag(level_flag), .evt_cnt(evt_cnt), .irq(irq)
    );

    typedef struct packed {
        logic [CH-1:0]       pos;
        logic [CH-1:0]       neg;
        logic [CH-1:0]       any;
        logic [CH-1:0]       flag;
        logic [CH*CNT_W-1:0] cnt;
        logic                irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state: raw samples since reset, counts as integers.
    logic [CH-1:0] samp[$];
    int            since_rst;
    logic [CH-1:0] m_mode_prev;
    logic [CH-1:0] m_flag;
    int            m_cnt[CH];

    task automatic model_edge();
        exp_t e;
        e = '0;
        if (rst) begin
            samp.delete();
            since_rst   = 0;
            m_mode_prev = '0;
            m_flag      = '0;
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        end else begin
            samp.push_back(d);
            if (samp.size() > 4) void'(samp.pop_front());
            e.irq = |(m_flag & irq_en);
            for (int c = 0; c < CH; c++) begin
                logic have, cur, prv, act, rise, fall, cnted;
                have  = (since_rst >= SD + 1);
                cur   = have ? samp[samp.size() - 1 - SD][c] : 1'b0;
                prv   = have ? samp[samp.size() - 2 - SD][c] : 1'b0;
                act   = have && (mode[c] == m_mode_prev[c]) && !mode[c];
                rise  = act && cur && !prv;
                fall  = act && !cur && prv;
                e.pos[c] = rise;
                e.neg[c] = fall;
                e.any[c] = rise || fall;
                cnted = (rise && edge_sel[2*c]) || (fall && edge_sel[2*c+1]);
                if (cnt_clr[c])                     m_cnt[c] = cnted ? 1 : 0;
                else if (cnted && m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
                if (mode[c] != m_mode_prev[c] || !mode[c] || clear[c]) m_flag[c] = 1'b0;
                else if (pulse[c])                                      m_flag[c] = 1'b1;
                e.cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
            end
            e.flag      = m_flag;
            m_mode_prev = mode;
            since_rst++;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            model_edge();
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pos_edge",   8'(pos_edge),   8'(e.pos));
                check("neg_edge",   8'(neg_edge),   8'(e.neg));
                check("any_edge",   8'(any_edge),   8'(e.any));
                check("level_flag", 8'(level_flag), 8'(e.flag));
                check("evt_cnt",    8'(evt_cnt),    8'(e.cnt));
                check("irq",        8'(irq),        8'(e.irq));
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; d = 4'hF; pulse = '0; clear = '0; mode = '0;
        edge_sel = 8'hFF; cnt_clr = '0; irq_en = '0;
        since_rst = 0; m_mode_prev = '0; m_flag = '0;
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;

        // High d held through reset, then a single falling edge on channel 2.
        cyc(3); rst = 1'b0; cyc(6);
        d[2] = 1'b0; cyc(4);
        // Rising edge on channel 0.
        d = '0; cyc(3); d[0] = 1'b1; cyc(4);
        // Pulse-to-level latch with clear priority and irq.
        mode[1] = 1'b1; cyc(2);
        pulse[1] = 1'b1; clear[1] = 1'b1; cyc(1);
        clear[1] = 1'b0; cyc(1);
        pulse[1] = 1'b0; irq_en[1] = 1'b1; cyc(3);
        clear[1] = 1'b1; cyc(1); clear[1] = 1'b0; cyc(2);
        mode[1] = 1'b0; cyc(2);
        // Saturation and clear-with-event on channel 3.
        for (int k = 0; k < 5; k++) begin d[3] = ~d[3]; cyc(1); end
        cyc(1);
        d[3] = ~d[3]; cnt_clr[3] = 1'b1; cyc(1); cnt_clr[3] = 1'b0; cyc(3);
        // Mode change coincident with a rising edge.
        d[0] = 1'b0; cyc(3); mode[0] = 1'b1; d[0] = 1'b1; cyc(2); mode[0] = 1'b0; cyc(3);
        // Reset in the middle of activity.
        d = 4'h5; cyc(1); d = 4'hA; rst = 1'b1; cyc(2); rst = 1'b0; cyc(5);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) d = 4'($urandom);
            if ($urandom_range(0, 31) == 0) mode = mode ^ 4'(1 << $urandom_range(0, 3));
            pulse   = 4'($urandom) & 4'($urandom);
            clear   = 4'($urandom) & 4'($urandom) & 4'($urandom);
            cnt_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 63) == 0) irq_en = 4'($urandom);
            if ($urandom_range(0, 127) == 0) edge_sel = 8'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            cyc(1);
        end

        rst = 1'b0; pulse = '0; clear = '0; cnt_clr = '0;
        cyc(3);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/level_pulse_array.md
LEVEL_PULSE_ARRAY -- requirements
Module: level_pulse_array

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 8, per-channel event counter width (2..16).
REQ-003 SHALL have port clk  input  1  single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port d  input  CH  per-channel level input.
REQ-006 SHALL have port pulse  input  CH  per-channel set pulse (level-latch mode).
REQ-007 SHALL have port clear  input  CH  per-channel latch clear.
REQ-008 SHALL have port mode  input  CH  per-channel mode: 0 = level-to-pulse, 1 = pulse-to-level.
REQ-009 SHALL have port edge_sel  input  2*CH  counted edge per channel: 00 none, 01 rising, 10 falling, 11 any.
REQ-010 SHALL have port cnt_clr  input  CH  per-channel counter clear.
REQ-011 SHALL have port irq_en  input  CH  per-channel interrupt enable.
REQ-012 SHALL have port pos_edge / neg_edge / any_edge  output  CH each  registered edge strobes.
REQ-013 SHALL have port level_flag  output  CH  registered latched level.
REQ-014 SHALL have port evt_cnt  output  CH*CNT_W  saturating event counts, channel i at [i*CNT_W +: CNT_W].
REQ-015 SHALL have port irq  output  1  registered OR of (level_flag & irq_en).

Function
REQ-016 SHALL keep a per-channel history register d_q loaded with the (optionally synchronised) d every cycle.
REQ-017 SHALL, in mode 0, assert pos_edge for exactly one cycle, the cycle after the first clock edge that samples d=1 with d_q=0; neg_edge and any_edge analogous; latency 1 cycle from sample.
REQ-018 SHALL hold pos/neg/any_edge at 0 for any channel in mode 1.
REQ-019 SHALL, in mode 1, set level_flag on pulse and clear it on clear; clear has priority over a simultaneous pulse.
REQ-020 SHALL hold level_flag at 0 for any channel in mode 0.
REQ-021 SHALL, in the cycle a channel's mode changes, suppress that channel's edge strobes and counting and force level_flag to 0.
REQ-022 SHALL increment evt_cnt in mode 0 on each edge matching edge_sel; rising and falling cannot coincide, so any increments by 1.
REQ-023 SHALL saturate evt_cnt at 2^CNT_W-1; further events leave it unchanged.
REQ-024 SHALL, on cnt_clr with a simultaneous counted event, load 1; on cnt_clr alone, load 0.
REQ-025 SHALL leave evt_cnt unchanged while a channel is in mode 1 (neither counts nor clears except via cnt_clr).
REQ-026 SHALL update irq one cycle after level_flag/irq_en change.

Reset
REQ-027 SHALL, while rst=1, drive all outputs to 0 and clear d_q, counters, flags and synchroniser stages.
REQ-028 SHALL, on the first cycle after rst deasserts, load d_q from d without reporting any edge (priming cycle), so a d held high through reset produces no pos_edge.
REQ-029 SHALL abandon any in-flight edge or latch state when rst asserts mid-operation; no strobe appears after rst deasserts for pre-reset activity.

Configuration
REQ-030 SHALL, with LEVEL_PULSE_SYNC_EN defined, pass d through a two-flop synchroniser per channel before d_q, making edge latency 3 cycles from d change and extending the priming window to 3 cycles.
REQ-031 SHALL, without LEVEL_PULSE_SYNC_EN, sample d directly into d_q (latency 1, priming 1 cycle).

Structure
REQ-032 SHALL place in shared package level_pulse_pkg: mode encoding constants (MODE_L2P=0, MODE_P2L=1) and edge_sel encodings (SEL_NONE, SEL_RISE, SEL_FALL, SEL_ANY).
REQ-033 SHALL implement one channel in sub-module level_pulse_chan, instantiated CH times by generate; top holds only the irq reduction register.

Verification
REQ-034 SHALL cover: CH=4, mode=0, d[0] 0->1 at cycle 10 -> pos_edge[0]=1 and any_edge[0]=1 at cycle 11 only, neg_edge[0]=0 (sync off).
REQ-035 SHALL cover: rst high 3 cycles with d=4'hF, release -> no edge strobes ever; subsequent d[2] 1->0 -> single neg_edge[2].
REQ-036 SHALL cover: mode[1]=1, pulse and clear same cycle -> level_flag[1] stays 0; pulse alone -> 1; with irq_en[1]=1, irq=1 one cycle later.
REQ-037 SHALL cover: CNT_W=2, edge_sel=11, toggle d[3] five times -> evt_cnt[3]=3 (saturated); cnt_clr with simultaneous edge -> 1.
REQ-038 SHALL cover: mode[0] toggled 0->1 in the same cycle d[0] rises -> no pos_edge[0], evt_cnt[0] unchanged, level_flag[0]=0.
REQ-039 SHALL cover: LEVEL_PULSE_SYNC_EN defined, d[0] rises at cycle 20 -> pos_edge[0] at cycle 23.
